// File: rtl/cpu_pkg.sv
// Shared definitions for the RAM arbiter: port indices, FSM encoding, size codes, operand bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    // Requester port indices; PORT_NONE doubles as the idle grant value.
    localparam logic [1:0] PORT_TRAP  = 2'd0;
    localparam logic [1:0] PORT_DATA  = 2'd1;
    localparam logic [1:0] PORT_FETCH = 2'd2;
    localparam logic [1:0] PORT_NONE  = 2'd3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    // RAM access size codes (2'b10 is unused by the RAM).
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    // Vector fetched by the trap unit on overflow.
    localparam logic [8:0] TRAP_OVF_ADDR = 9'd448;

    // One requester's operands as captured at grant time.
    typedef struct packed {
        logic        rw;
        logic [1:0]  size;
        logic [8:0]  addr;
        logic [31:0] wdata;
    } ram_op_t;

    // Completion strobe vector for a grant index; idle grant strobes nothing.
    function automatic logic [2:0] port_onehot(input logic [1:0] p);
        logic [2:0] oh;
        oh = 3'b000;
        case (p)
            PORT_TRAP:  oh = 3'b001;
            PORT_DATA:  oh = 3'b010;
            PORT_FETCH: oh = 3'b100;
            default:    oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/arb_priority.sv
// Grant picker: trap has fixed top priority; data and fetch alternate via a one-bit pointer.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller only consults it while idle.
//   req       : per-port request (0 trap, 1 data, 2 fetch)
//   ptr_fetch : 1 = fetch wins a data/fetch tie, 0 = data wins
//   grant_idx : winning port index, PORT_NONE when nothing requests
//   grant_vld : a port was selected
import cpu_pkg::*;

module arb_priority (
    input  logic [2:0] req,
    input  logic       ptr_fetch,
    output logic [1:0] grant_idx,
    output logic       grant_vld
);

    always_comb begin
        grant_idx = PORT_NONE;
        grant_vld = 1'b0;
        if (req[0]) begin
            grant_idx = PORT_TRAP;
            grant_vld = 1'b1;
        end else if (req[1] && req[2]) begin
            grant_idx = ptr_fetch ? PORT_FETCH : PORT_DATA;
            grant_vld = 1'b1;
        end else if (req[1]) begin
            grant_idx = PORT_DATA;
            grant_vld = 1'b1;
        end else if (req[2]) begin
            grant_idx = PORT_FETCH;
            grant_vld = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one 512-byte RAM between trap, data and fetch requesters over the MFA/MFC handshake.
// Latency: request sampled in IDLE -> reqMFC in the DONE cycle, 3 edges + one per RAM wait cycle.
// Backpressure: requesters hold reqMFA until reqMFC; a watchdog ends accesses the RAM never acknowledges.
//   Clk, reset                        : clock, async active-low reset
//   reqMFA/reqRW/reqDataSizeN/
//   reqAddressN/reqDataInN            : per-port request and operands
//   reqMFC, reqDataOut, busError      : per-port completion, shared read data, timeout flag
//   grant                             : owning port, 2'b11 when idle
//   ram*                              : RAM-side strobe, operands and completion
import cpu_pkg::*;

module ram_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [2:0]  reqMFA,
    input  logic [2:0]  reqRW,
    input  logic [1:0]  reqDataSize0,
    input  logic [1:0]  reqDataSize1,
    input  logic [1:0]  reqDataSize2,
    input  logic [8:0]  reqAddress0,
    input  logic [8:0]  reqAddress1,
    input  logic [8:0]  reqAddress2,
    input  logic [31:0] reqDataIn0,
    input  logic [31:0] reqDataIn1,
    input  logic [31:0] reqDataIn2,
    output logic [2:0]  reqMFC,
    output logic [31:0] reqDataOut,
    output logic        busError,
    output logic [1:0]  grant,
    output logic        ramMFA,
    output logic        ramRW,
    output logic [1:0]  ramDataSize,
    output logic [8:0]  ramAddress,
    output logic [31:0] ramDataIn,
    input  logic [31:0] ramDataOut,
    input  logic        ramMFC
);

    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

    arb_state_t state_q;
    arb_state_t state_d;
    logic [7:0] wd_q;
    logic       ptr_fetch_q;

    logic [1:0] pick_idx;
    logic       pick_vld;
    ram_op_t    pick_op;

    logic       wait_ok;
    logic       wait_tmo;

    arb_priority u_pick (
        .req       (reqMFA),
        .ptr_fetch (ptr_fetch_q),
        .grant_idx (pick_idx),
        .grant_vld (pick_vld)
    );

    // Operand mux for the port the picker chose.
    always_comb begin
        pick_op = '0;
        case (pick_idx)
            PORT_TRAP:  pick_op = '{rw: reqRW[0], size: reqDataSize0, addr: reqAddress0, wdata: reqDataIn0};
            PORT_DATA:  pick_op = '{rw: reqRW[1], size: reqDataSize1, addr: reqAddress1, wdata: reqDataIn1};
            PORT_FETCH: pick_op = '{rw: reqRW[2], size: reqDataSize2, addr: reqAddress2, wdata: reqDataIn2};
            default:    pick_op = '0;
        endcase
    end

    // Next-state logic. A RAM acknowledge on the watchdog's last cycle is
    // still a success, so the acknowledge is tested before the timeout.
    always_comb begin
        state_d  = state_q;
        wait_ok  = 1'b0;
        wait_tmo = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (ramMFC) begin
                    wait_ok = 1'b1;
                    state_d = ARB_DONE;
                end else if ((wd_q + 8'd1) == WD_LIMIT) begin
                    wait_tmo = 1'b1;
                    state_d  = ARB_DONE;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath. Completion outputs are loaded on the WAIT->DONE edge so they
    // are visible for exactly the DONE cycle; requests arriving during DONE
    // are never sampled because only IDLE consults the picker.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            grant       <= PORT_NONE;
            ramMFA      <= 1'b0;
            ramRW       <= 1'b0;
            ramDataSize <= SIZE_BYTE;
            ramAddress  <= '0;
            ramDataIn   <= '0;
            reqMFC      <= '0;
            reqDataOut  <= '0;
            busError    <= 1'b0;
            wd_q        <= '0;
            ptr_fetch_q <= 1'b0;
        end else begin
            reqMFC   <= '0;
            busError <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_vld) begin
                        grant       <= pick_idx;
                        ramRW       <= pick_op.rw;
                        ramDataSize <= pick_op.size;
                        ramAddress  <= pick_op.addr;
                        ramDataIn   <= pick_op.wdata;
                    end
                end
                ARB_ISSUE: begin
                    ramMFA <= 1'b1;
                    wd_q   <= '0;
                end
                ARB_WAIT: begin
                    if (wait_ok) begin
                        ramMFA <= 1'b0;
                        reqMFC <= port_onehot(grant);
                        if (ramRW) begin
                            reqDataOut <= ramDataOut;
                        end
                    end else if (wait_tmo) begin
                        ramMFA     <= 1'b0;
                        reqMFC     <= port_onehot(grant);
                        busError   <= 1'b1;
                        reqDataOut <= '0;
                    end else begin
                        wd_q <= wd_q + 8'd1;
                    end
                end
                ARB_DONE: begin
                    // Round-robin hand-off between data and fetch; trap leaves it alone.
                    if (grant == PORT_DATA) begin
                        ptr_fetch_q <= 1'b1;
                    end else if (grant == PORT_FETCH) begin
                        ptr_fetch_q <= 1'b0;
                    end
                    grant <= PORT_NONE;
                end
                default: begin
                    grant <= PORT_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small latency-programmable RAM responder.
// Latency: n/a.
// Backpressure: n/a.
import cpu_pkg::*;

module tb_ram_arbiter;

    logic        Clk;
    logic        reset;
    logic [2:0]  reqMFA;
    logic [2:0]  reqRW;
    logic [1:0]  reqDataSize0, reqDataSize1, reqDataSize2;
    logic [8:0]  reqAddress0, reqAddress1, reqAddress2;
    logic [31:0] reqDataIn0, reqDataIn1, reqDataIn2;
    logic [2:0]  reqMFC;
    logic [31:0] reqDataOut;
    logic        busError;
    logic [1:0]  grant;
    logic        ramMFA, ramRW;
    logic [1:0]  ramDataSize;
    logic [8:0]  ramAddress;
    logic [31:0] ramDataIn;
    logic [31:0] ramDataOut;
    logic        ramMFC;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int t_req  = 0;
    int ram_lat = 0;
    int ram_cnt = 0;

    ram_arbiter #(.TIMEOUT(4)) dut (
        .Clk(Clk), .reset(reset),
        .reqMFA(reqMFA), .reqRW(reqRW),
        .reqDataSize0(reqDataSize0), .reqDataSize1(reqDataSize1), .reqDataSize2(reqDataSize2),
        .reqAddress0(reqAddress0), .reqAddress1(reqAddress1), .reqAddress2(reqAddress2),
        .reqDataIn0(reqDataIn0), .reqDataIn1(reqDataIn1), .reqDataIn2(reqDataIn2),
        .reqMFC(reqMFC), .reqDataOut(reqDataOut), .busError(busError), .grant(grant),
        .ramMFA(ramMFA), .ramRW(ramRW), .ramDataSize(ramDataSize),
        .ramAddress(ramAddress), .ramDataIn(ramDataIn),
        .ramDataOut(ramDataOut), .ramMFC(ramMFC)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // RAM model: acknowledges on the (ram_lat+1)-th cycle that ramMFA is high.
    always @(negedge Clk) begin
        if (ramMFA) begin
            ramMFC = (ram_cnt == ram_lat);
            ram_cnt = ram_cnt + 1;
        end else begin
            ramMFC = 1'b0;
            ram_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_port(input int p, input logic rw, input logic [1:0] sz,
                            input logic [8:0] a, input logic [31:0] d);
        reqRW[p] = rw;
        case (p)
            0: begin reqDataSize0 = sz; reqAddress0 = a; reqDataIn0 = d; end
            1: begin reqDataSize1 = sz; reqAddress1 = a; reqDataIn1 = d; end
            default: begin reqDataSize2 = sz; reqAddress2 = a; reqDataIn2 = d; end
        endcase
    endtask

    task automatic flip_addr(input int p);
        case (p)
            0: reqAddress0 = reqAddress0 ^ 9'h1FF;
            1: reqAddress1 = reqAddress1 ^ 9'h1FF;
            default: reqAddress2 = reqAddress2 ^ 9'h1FF;
        endcase
    endtask

    task automatic raise(input logic [2:0] m);
        @(posedge Clk);
        #1;
        reqMFA = reqMFA | m;
        t_req = cyc;
    endtask

    // Follows one access of port p from RAM strobe to completion, then drops the request.
    task automatic serve(input string tag, input int p, input logic [8:0] a, input logic rw,
                         input logic [1:0] sz, input logic [31:0] din, input int lat,
                         input logic err, input logic [31:0] dout);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge Clk);
            if (ramMFA) seen = 1'b1;
        end
        check({tag, "_mfa_up"}, 32'(seen), 32'd1);
        check({tag, "_grant"}, 32'(grant), 32'(p));
        check({tag, "_addr"}, 32'(ramAddress), 32'(a));
        check({tag, "_rw"}, 32'(ramRW), 32'(rw));
        check({tag, "_size"}, 32'(ramDataSize), 32'(sz));
        check({tag, "_din"}, ramDataIn, din);
        // Operands move mid-access; the registered copy must not.
        flip_addr(p);
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge Clk);
            if (reqMFC != 3'b000) seen = 1'b1;
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
        check({tag, "_mfc"}, 32'(reqMFC), 32'(3'b001 << p));
        if (lat >= 0) check({tag, "_lat"}, 32'(cyc - t_req), 32'(lat));
        check({tag, "_berr"}, 32'(busError), 32'(err));
        check({tag, "_mfa_drop"}, 32'(ramMFA), 32'd0);
        check({tag, "_hold"}, 32'(ramAddress), 32'(a));
        if (rw || err) check({tag, "_dout"}, reqDataOut, dout);
        @(posedge Clk);
        #1;
        reqMFA[p] = 1'b0;
        flip_addr(p);
        @(negedge Clk);
        check({tag, "_pulse"}, {29'd0, reqMFC}, 32'd0);
    endtask

    initial begin
        bit seen;
        logic [2:0] mfc_seen;
        reset = 1'b1;
        reqMFA = '0; reqRW = '0;
        reqDataSize0 = '0; reqDataSize1 = '0; reqDataSize2 = '0;
        reqAddress0 = '0; reqAddress1 = '0; reqAddress2 = '0;
        reqDataIn0 = '0; reqDataIn1 = '0; reqDataIn2 = '0;
        ramDataOut = '0; ramMFC = 1'b0;

        #1 reset = 1'b0;
        #2;
        check("rst_grant", 32'(grant), 32'd3);
        check("rst_mfa", 32'(ramMFA), 32'd0);
        check("rst_mfc", 32'(reqMFC), 32'd0);
        check("rst_berr", 32'(busError), 32'd0);
        check("rst_addr", 32'(ramAddress), 32'd0);
        check("rst_din", ramDataIn, 32'd0);
        check("rst_dout", reqDataOut, 32'd0);
        check("rst_size", 32'(ramDataSize), 32'd0);
        repeat (2) @(posedge Clk);
        #2 reset = 1'b1;

        // Single fetch read, RAM answers after 2 wait cycles.
        set_port(2, 1'b1, SIZE_WORD, 9'h004, 32'h0);
        ram_lat = 2; ramDataOut = 32'h2001000A;
        raise(3'b100);
        serve("fetch1", 2, 9'h004, 1'b1, SIZE_WORD, 32'h0, 5, 1'b0, 32'h2001000A);
        check("idle_grant", 32'(grant), 32'd3);

        // Data vs fetch contention from reset pointer: data then fetch.
        set_port(1, 1'b1, SIZE_HALF, 9'h020, 32'h0000_0001);
        set_port(2, 1'b1, SIZE_WORD, 9'h008, 32'h0000_0002);
        ram_lat = 0; ramDataOut = 32'h11112222;
        raise(3'b110);
        serve("rrA_data", 1, 9'h020, 1'b1, SIZE_HALF, 32'h1, 3, 1'b0, 32'h11112222);
        ramDataOut = 32'h33334444;
        serve("rrA_fetch", 2, 9'h008, 1'b1, SIZE_WORD, 32'h2, -1, 1'b0, 32'h33334444);

        // All three at once: trap first, pointer untouched so data, then fetch.
        set_port(0, 1'b1, SIZE_WORD, TRAP_OVF_ADDR, 32'h0);
        ramDataOut = 32'h0000_01C0;
        raise(3'b111);
        serve("trap", 0, TRAP_OVF_ADDR, 1'b1, SIZE_WORD, 32'h0, 3, 1'b0, 32'h0000_01C0);
        ramDataOut = 32'h5555AAAA;
        serve("trap_data", 1, 9'h020, 1'b1, SIZE_HALF, 32'h1, -1, 1'b0, 32'h5555AAAA);
        serve("trap_fetch", 2, 9'h008, 1'b1, SIZE_WORD, 32'h2, -1, 1'b0, 32'h5555AAAA);

        // Data-only write moves the pointer to fetch; next tie goes to fetch.
        set_port(1, 1'b0, SIZE_BYTE, 9'h030, 32'h0000_00A5);
        raise(3'b010);
        serve("data_w", 1, 9'h030, 1'b0, SIZE_BYTE, 32'hA5, 3, 1'b0, 32'h0);
        set_port(1, 1'b1, SIZE_WORD, 9'h034, 32'h0);
        ramDataOut = 32'h0BADF00D;
        raise(3'b110);
        serve("rrB_fetch", 2, 9'h008, 1'b1, SIZE_WORD, 32'h2, 3, 1'b0, 32'h0BADF00D);
        serve("rrB_data", 1, 9'h034, 1'b1, SIZE_WORD, 32'h0, -1, 1'b0, 32'h0BADF00D);

        // Timeout on a data write the RAM never acknowledges, then a normal read.
        ram_lat = 1000;
        set_port(1, 1'b0, SIZE_WORD, 9'h010, 32'hDEADBEEF);
        raise(3'b010);
        serve("tmo", 1, 9'h010, 1'b0, SIZE_WORD, 32'hDEADBEEF, 6, 1'b1, 32'h0);
        ram_lat = 0; ramDataOut = 32'hCAFEF00D;
        set_port(1, 1'b1, SIZE_WORD, 9'h014, 32'h0);
        raise(3'b010);
        serve("post_tmo", 1, 9'h014, 1'b1, SIZE_WORD, 32'h0, 3, 1'b0, 32'hCAFEF00D);

        // Reset asserted while waiting on the RAM.
        ram_lat = 1000;
        set_port(2, 1'b1, SIZE_WORD, 9'h040, 32'h0);
        raise(3'b100);
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge Clk);
            if (ramMFA) seen = 1'b1;
        end
        check("rmid_mfa_up", 32'(seen), 32'd1);
        @(negedge Clk);
        #1 reset = 1'b0;
        reqMFA = '0;
        #1;
        check("rmid_mfa", 32'(ramMFA), 32'd0);
        check("rmid_grant", 32'(grant), 32'd3);
        check("rmid_addr", 32'(ramAddress), 32'd0);
        check("rmid_rw", 32'(ramRW), 32'd0);
        check("rmid_dout", reqDataOut, 32'd0);
        mfc_seen = reqMFC;
        repeat (3) begin
            @(negedge Clk);
            mfc_seen = mfc_seen | reqMFC;
        end
        check("rmid_no_mfc", 32'(mfc_seen), 32'd0);
        @(posedge Clk);
        #2 reset = 1'b1;
        ram_lat = 1; ramDataOut = 32'h7777_0001;
        raise(3'b100);
        serve("rmid_fresh", 2, 9'h040, 1'b1, SIZE_WORD, 32'h0, 4, 1'b0, 32'h7777_0001);

        // Acknowledge on the very cycle the watchdog expires: success.
        ram_lat = 3; ramDataOut = 32'h1234_5678;
        set_port(1, 1'b1, SIZE_HALF, 9'h0FC, 32'h0);
        raise(3'b010);
        serve("edge", 1, 9'h0FC, 1'b1, SIZE_HALF, 32'h0, 6, 1'b0, 32'h1234_5678);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
